// File: rtl/k16_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k16_bus_pkg
// Purpose  : Shared types and default constants for the K16 bus RAM slave:
//            bus FSM state encoding, default data/address widths, wait-state
//            limit and wait counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package k16_bus_pkg;

    localparam int c_data_w   = 16;  // default data word width
    localparam int c_addr_w   = 16;  // default word address width
    localparam int c_wait_max = 15;  // largest supported WAIT_STATES value
    localparam int c_cnt_w    = 4;   // wait counter width, covers c_wait_max

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } bus_state_t;

endpackage : k16_bus_pkg
`default_nettype wire

// File: rtl/k16_bus_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : k16_bus_ram_if
// Purpose  : Request/acknowledge bus between a K16 bus master and the RAM
//            slave.
// Signals  : req, write, address, data_in  - master -> slave, sampled with req
//            data_out, err                 - slave -> master, valid with ack
//            ack                           - one-cycle completion pulse
//            hold                          - slave inserting wait states
// Revision : 1.0 - initial release
// ============================================================================
interface k16_bus_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              ack;
    logic              hold;
    logic              err;

    modport master (
        output req, write, address, data_in,
        input  data_out, ack, hold, err
    );

    modport slave (
        input  req, write, address, data_in,
        output data_out, ack, hold, err
    );
endinterface : k16_bus_ram_if
`default_nettype wire

// File: rtl/k16_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : k16_ram_array
// Purpose  : Single-port word RAM, synchronous write, registered read, no
//            reset. On a write the read register takes the written word
//            (write-first), so the port output always shows the word last
//            accessed. Contents and read register only change when i_en=1.
// Ports    : clk      - clock
//            i_en     - access enable
//            i_we     - 1 = write, 0 = read (qualified by i_en)
//            i_addr   - word address, must be < DEPTH when i_en=1
//            i_wdata  - write data
//            o_rdata  - registered access data
// Revision : 1.0 - initial release
// ============================================================================
module k16_ram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 65536,
    parameter int AW     = 16
) (
    input  wire logic              clk,
    input  wire logic              i_en,
    input  wire logic              i_we,
    input  wire logic [AW-1:0]     i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
                o_rdata       <= i_wdata;
            end else begin
                o_rdata       <= r_mem[i_addr];
            end
        end
    end

endmodule : k16_ram_array
`default_nettype wire

// File: rtl/k16_bus_ram.sv
`default_nettype none
// ============================================================================
// Module   : k16_bus_ram
// Purpose  : Bus slave wrapping a word RAM. Accepts one access per request,
//            inserts WAIT_STATES wait cycles (hold=1), then pulses ack for one
//            cycle with read data / write echo and an out-of-range flag.
// Ports    : clk   - clock, all state changes on rising edge
//            reset - asynchronous active-low reset
//            bus   - k16_bus_ram_if slave modport (req/write/address/data_in
//                    in; data_out/ack/hold/err out)
// Revision : 1.0 - initial release
// ============================================================================
module k16_bus_ram
    import k16_bus_pkg::*;
#(
    parameter int DATA_W      = c_data_w,
    parameter int ADDR_W      = c_addr_w,
    parameter int DEPTH       = 65536,
    parameter int WAIT_STATES = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    k16_bus_ram_if.slave bus
);

    localparam int                 c_ram_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_depth_ext = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_wait_ld   = c_cnt_w'(WAIT_STATES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    bus_state_t           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_write;
    logic                 r_oor;
    logic                 r_rd_valid;
    logic [c_ram_aw-1:0]  r_addr;
    logic [DATA_W-1:0]    r_wdata;

    logic                 w_accept;
    logic                 w_live_oor;
    logic                 w_wait_done;
    logic                 w_ram_en;
    logic                 w_ram_we;
    logic [c_ram_aw-1:0]  w_ram_addr;
    logic [DATA_W-1:0]    w_ram_wdata;
    logic [DATA_W-1:0]    w_ram_rdata;

    assign w_live_oor  = ({1'b0, bus.address} >= c_depth_ext);
    assign w_accept    = bus.req && (r_state != ST_WAIT);
    assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == c_cnt_one);

    // The RAM access happens on the edge that enters ACK so its registered
    // output is ready during ack. With no wait states that edge is the accept
    // edge itself, so the live bus fields drive the RAM; otherwise the fields
    // latched at accept do.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = r_write;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_wdata;
        if (WAIT_STATES == 0) begin
            w_ram_en    = w_accept && !w_live_oor;
            w_ram_we    = bus.write;
            w_ram_addr  = bus.address[c_ram_aw-1:0];
            w_ram_wdata = bus.data_in;
        end else begin
            w_ram_en    = w_wait_done && !r_oor;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_oor      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            bus.ack    <= 1'b0;
            bus.hold   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.ack  <= 1'b0;
            bus.hold <= 1'b0;
            bus.err  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ACK: begin
                    if (bus.req) begin
                        r_write <= bus.write;
                        r_addr  <= bus.address[c_ram_aw-1:0];
                        r_wdata <= bus.data_in;
                        r_oor   <= w_live_oor;
                        r_cnt   <= c_wait_ld;
                        if (WAIT_STATES == 0) begin
                            r_state    <= ST_ACK;
                            bus.ack    <= 1'b1;
                            bus.err    <= w_live_oor;
                            r_rd_valid <= !w_live_oor;
                        end else begin
                            r_state  <= ST_WAIT;
                            bus.hold <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state    <= ST_ACK;
                        bus.ack    <= 1'b1;
                        bus.err    <= r_oor;
                        r_rd_valid <= !r_oor;
                    end else begin
                        bus.hold <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    k16_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (c_ram_aw)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // The RAM itself has no reset and only updates on an access, so gating
    // its output gives zero after reset or an out-of-range ack, and otherwise
    // holds the last acknowledged word between acks.
    assign bus.data_out = r_rd_valid ? w_ram_rdata : '0;

endmodule : k16_bus_ram
`default_nettype wire

// File: tb/tb_k16_bus_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_k16_bus_ram
// Purpose  : Self-checking bench for k16_bus_ram. Three instances cover
//            WAIT_STATES 0/3/2 with DEPTH 256/65536/1000; a select steers the
//            shared master signals to one instance at a time. Expected data
//            comes from a per-instance array model of the memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k16_bus_ram;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sel;
    logic        req;
    logic        write;
    logic [15:0] address;
    logic [15:0] data_in;

    logic        obs_ack, obs_hold, obs_err;
    logic [15:0] obs_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ref_mem [3][65536];
    bit          ref_ok  [3][65536];

    always #5 clk = ~clk;

    k16_bus_ram_if #(.DATA_W(16), .ADDR_W(16)) if_a ();
    k16_bus_ram_if #(.DATA_W(16), .ADDR_W(16)) if_b ();
    k16_bus_ram_if #(.DATA_W(16), .ADDR_W(16)) if_c ();

    assign if_a.req = req && (sel == 2'd0);
    assign if_b.req = req && (sel == 2'd1);
    assign if_c.req = req && (sel == 2'd2);
    assign if_a.write = write;   assign if_b.write = write;   assign if_c.write = write;
    assign if_a.address = address; assign if_b.address = address; assign if_c.address = address;
    assign if_a.data_in = data_in; assign if_b.data_in = data_in; assign if_c.data_in = data_in;

    k16_bus_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH(256),   .WAIT_STATES(0))
        u_dut_a (.clk(clk), .reset(reset_n), .bus(if_a.slave));
    k16_bus_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH(65536), .WAIT_STATES(3))
        u_dut_b (.clk(clk), .reset(reset_n), .bus(if_b.slave));
    k16_bus_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH(1000),  .WAIT_STATES(2))
        u_dut_c (.clk(clk), .reset(reset_n), .bus(if_c.slave));

    always_comb begin
        obs_ack = if_a.ack; obs_hold = if_a.hold; obs_err = if_a.err; obs_data = if_a.data_out;
        case (sel)
            2'd1:    begin obs_ack = if_b.ack; obs_hold = if_b.hold; obs_err = if_b.err; obs_data = if_b.data_out; end
            2'd2:    begin obs_ack = if_c.ack; obs_hold = if_c.hold; obs_err = if_c.err; obs_data = if_c.data_out; end
            default: ;
        endcase
    end

    function automatic int ws_of(input logic [1:0] s);
        return (s == 2'd1) ? 3 : (s == 2'd2) ? 2 : 0;
    endfunction

    function automatic int depth_of(input logic [1:0] s);
        return (s == 2'd1) ? 65536 : (s == 2'd2) ? 1000 : 256;
    endfunction

    // Reference memory behaviour: out-of-range -> err, zero data, no write;
    // write echoes its data; read returns last written word (known=0 if none).
    function automatic void model_access(input logic [1:0] s, input logic wr,
                                         input logic [15:0] a, input logic [15:0] d,
                                         output logic e, output logic [15:0] q, output bit known);
        e = (int'(a) >= depth_of(s));
        known = 1'b1;
        if (e) q = 16'h0000;
        else if (wr) begin q = d; ref_mem[s][a] = d; ref_ok[s][a] = 1'b1; end
        else begin q = ref_mem[s][a]; known = ref_ok[s][a]; end
    endfunction

    // Issue one access and observe until ack (bounded); no checking here.
    task automatic access(input logic [1:0] s, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat, output int holds,
                          output logic [15:0] dout, output logic e, output bit tmo);
        @(negedge clk);
        sel = s; req = 1'b1; write = wr; address = a; data_in = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0; holds = 0; tmo = 1'b1; dout = 16'h0; e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (obs_hold) holds++;
            if (obs_ack) begin lat = k; dout = obs_data; e = obs_err; tmo = 1'b0; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 1'b0; write = 1'b0; address = '0; data_in = '0; sel = 2'd0;
        repeat (2) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            #1 sel = 2'(s);
            #1;
            n_tests++;
            if ({obs_ack, obs_hold, obs_err, obs_data} !== 19'h0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d got ack=%b hold=%b err=%b data=%h want all 0",
                         s, obs_ack, obs_hold, obs_err, obs_data);
            end
        end
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, holds; logic [15:0] q, eq; logic e, ee; bit tmo, kn;
        model_access(2'd0, 1'b1, 16'h0000, 16'h6257, ee, eq, kn);
        access(2'd0, 1'b1, 16'h0000, 16'h6257, lat, holds, q, e, tmo);
        n_tests++; if (tmo || lat !== 1 || holds !== 0) begin n_fail++;
            $display("FAIL basic_wr_timing got lat=%0d holds=%0d tmo=%0d want lat=1 holds=0", lat, holds, tmo); end
        n_tests++; if (q !== 16'h6257 || e !== 1'b0) begin n_fail++;
            $display("FAIL basic_wr_echo got data=%h err=%b want 6257 err=0", q, e); end
        model_access(2'd0, 1'b0, 16'h0000, 16'h0, ee, eq, kn);
        access(2'd0, 1'b0, 16'h0000, 16'hFFFF, lat, holds, q, e, tmo);
        n_tests++; if (tmo || lat !== 1 || holds !== 0) begin n_fail++;
            $display("FAIL basic_rd_timing got lat=%0d holds=%0d tmo=%0d want lat=1 holds=0", lat, holds, tmo); end
        n_tests++; if (q !== eq || e !== 1'b0) begin n_fail++;
            $display("FAIL basic_rd_data got data=%h err=%b want %h err=0", q, e, eq); end
    endtask

    task automatic test_wait_states();
        int lat, holds; logic [15:0] q, eq; logic e, ee; bit tmo, kn;
        model_access(2'd1, 1'b1, 16'h0001, 16'h0480, ee, eq, kn);
        access(2'd1, 1'b1, 16'h0001, 16'h0480, lat, holds, q, e, tmo);
        n_tests++; if (tmo || lat !== 4 || holds !== 3) begin n_fail++;
            $display("FAIL ws3_wr_timing got lat=%0d holds=%0d tmo=%0d want lat=4 holds=3", lat, holds, tmo); end
        model_access(2'd1, 1'b0, 16'h0001, 16'h0, ee, eq, kn);
        access(2'd1, 1'b0, 16'h0001, 16'h0000, lat, holds, q, e, tmo);
        n_tests++; if (tmo || lat !== 4 || holds !== 3) begin n_fail++;
            $display("FAIL ws3_rd_timing got lat=%0d holds=%0d tmo=%0d want lat=4 holds=3", lat, holds, tmo); end
        n_tests++; if (q !== 16'h0480 || e !== 1'b0) begin n_fail++;
            $display("FAIL ws3_rd_data got data=%h err=%b want 0480 err=0", q, e); end
        @(posedge clk); #1;
        n_tests++; if (obs_ack !== 1'b0 || obs_err !== 1'b0 || obs_hold !== 1'b0 || obs_data !== 16'h0480) begin n_fail++;
            $display("FAIL ws3_after_ack got ack=%b hold=%b err=%b data=%h want 0 0 0 0480",
                     obs_ack, obs_hold, obs_err, obs_data); end
    endtask

    task automatic test_back_to_back();
        int lat, holds; logic [15:0] q, eq; logic e, ee; bit tmo, kn;
        logic [15:0] exp_d [4];
        logic [7:0]  ack_v, hold_v;
        for (int i = 0; i < 4; i++) begin
            model_access(2'd0, 1'b1, 16'(i), 16'($urandom), ee, eq, kn);
            access(2'd0, 1'b1, 16'(i), eq, lat, holds, q, e, tmo);
            exp_d[i] = eq;
        end
        // four reads with req held high: one ack per cycle on instance a
        @(negedge clk);
        sel = 2'd0; req = 1'b1; write = 1'b0; address = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_tests++; if (obs_ack !== 1'b1 || obs_data !== exp_d[k] || obs_hold !== 1'b0) begin n_fail++;
                $display("FAIL b2b_ws0_rd%0d got ack=%b hold=%b data=%h want ack=1 hold=0 data=%h",
                         k, obs_ack, obs_hold, obs_data, exp_d[k]); end
            address = 16'(k + 1);
        end
        req = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (obs_ack !== 1'b0 || obs_data !== exp_d[3]) begin n_fail++;
            $display("FAIL b2b_ws0_end got ack=%b data=%h want ack=0 data=%h", obs_ack, obs_data, exp_d[3]); end
        // req held high on the 3-wait-state instance: requests in WAIT ignored
        @(negedge clk);
        sel = 2'd1; req = 1'b1; write = 1'b0; address = 16'h0001;
        ack_v = '0; hold_v = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            ack_v[k] = obs_ack; hold_v[k] = obs_hold;
        end
        req = 1'b0;
        n_tests++; if (ack_v !== 8'b1000_1000 || hold_v !== 8'b0111_0111) begin n_fail++;
            $display("FAIL b2b_ws3_pattern got ack=%b hold=%b want ack=10001000 hold=01110111", ack_v, hold_v); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        int lat, holds; logic [15:0] q, eq; logic e, ee; bit tmo, kn;
        model_access(2'd0, 1'b1, 16'h0100, 16'hBEEF, ee, eq, kn);
        access(2'd0, 1'b1, 16'h0100, 16'hBEEF, lat, holds, q, e, tmo);
        n_tests++; if (tmo || lat !== 1 || e !== 1'b1 || q !== 16'h0000) begin n_fail++;
            $display("FAIL oor_wr got lat=%0d err=%b data=%h want lat=1 err=1 data=0000", lat, e, q); end
        @(posedge clk); #1;
        n_tests++; if (obs_err !== 1'b0 || obs_data !== 16'h0000) begin n_fail++;
            $display("FAIL oor_after_ack got err=%b data=%h want err=0 data=0000", obs_err, obs_data); end
        model_access(2'd0, 1'b0, 16'h0000, 16'h0, ee, eq, kn);
        access(2'd0, 1'b0, 16'h0000, 16'h0, lat, holds, q, e, tmo);
        n_tests++; if (tmo || e !== 1'b0 || q !== eq) begin n_fail++;
            $display("FAIL oor_no_alias got err=%b data=%h want err=0 data=%h", e, q, eq); end
        // boundary on the non-power-of-two instance: 999 valid, 1000 not
        model_access(2'd2, 1'b1, 16'd999, 16'hA5C3, ee, eq, kn);
        access(2'd2, 1'b1, 16'd999, 16'hA5C3, lat, holds, q, e, tmo);
        n_tests++; if (tmo || lat !== 3 || e !== 1'b0 || q !== 16'hA5C3) begin n_fail++;
            $display("FAIL depth_last got lat=%0d err=%b data=%h want lat=3 err=0 data=a5c3", lat, e, q); end
        access(2'd2, 1'b0, 16'd1000, 16'h0, lat, holds, q, e, tmo);
        n_tests++; if (tmo || lat !== 3 || holds !== 2 || e !== 1'b1 || q !== 16'h0000) begin n_fail++;
            $display("FAIL depth_over got lat=%0d holds=%0d err=%b data=%h want 3 2 1 0000", lat, holds, e, q); end
    endtask

    task automatic test_reset_mid_access();
        int lat, holds; logic [15:0] q, eq; logic e, ee; bit tmo, kn;
        logic [7:0] acks;
        model_access(2'd2, 1'b1, 16'h0010, 16'h5555, ee, eq, kn);
        access(2'd2, 1'b1, 16'h0010, 16'h5555, lat, holds, q, e, tmo);
        @(negedge clk);
        sel = 2'd2; req = 1'b1; write = 1'b1; address = 16'h0010; data_in = 16'h1234;
        @(posedge clk); #1;
        req = 1'b0;
        n_tests++; if (obs_hold !== 1'b1 || obs_ack !== 1'b0) begin n_fail++;
            $display("FAIL midrst_first_wait got hold=%b ack=%b want hold=1 ack=0", obs_hold, obs_ack); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if ({obs_ack, obs_hold, obs_err, obs_data} !== 19'h0) begin n_fail++;
            $display("FAIL midrst_async got ack=%b hold=%b err=%b data=%h want all 0",
                     obs_ack, obs_hold, obs_err, obs_data); end
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        acks = '0;
        for (int k = 0; k < 8; k++) begin @(posedge clk); #1; acks[k] = obs_ack; end
        n_tests++; if (acks !== 8'h00) begin n_fail++;
            $display("FAIL midrst_no_ack got ack history=%b want 00000000", acks); end
        model_access(2'd2, 1'b0, 16'h0010, 16'h0, ee, eq, kn);
        access(2'd2, 1'b0, 16'h0010, 16'h0, lat, holds, q, e, tmo);
        n_tests++; if (tmo || q !== 16'h5555 || e !== 1'b0) begin n_fail++;
            $display("FAIL midrst_kept got data=%h err=%b tmo=%0d want 5555 err=0", q, e, tmo); end
    endtask

    task automatic test_random();
        int lat, holds; logic [15:0] q, eq, a, d; logic e, ee, wr; bit tmo, kn;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 30; i++) begin
                wr = 1'($urandom_range(0, 1));
                d  = 16'($urandom);
                a  = 16'($urandom_range(0, 15));
                if (s != 1 && $urandom_range(0, 7) == 0) a = 16'(depth_of(2'(s)) + int'($urandom_range(0, 20)));
                model_access(2'(s), wr, a, d, ee, eq, kn);
                access(2'(s), wr, a, d, lat, holds, q, e, tmo);
                n_tests++; if (tmo || lat !== ws_of(2'(s)) + 1 || holds !== ws_of(2'(s))) begin n_fail++;
                    $display("FAIL rand_timing dut%0d addr=%h got lat=%0d holds=%0d tmo=%0d want lat=%0d holds=%0d",
                             s, a, lat, holds, tmo, ws_of(2'(s)) + 1, ws_of(2'(s))); end
                n_tests++; if (e !== ee || (kn && q !== eq)) begin n_fail++;
                    $display("FAIL rand_data dut%0d wr=%b addr=%h got err=%b data=%h want err=%b data=%h",
                             s, wr, a, e, q, ee, eq); end
                @(posedge clk); #1;
                n_tests++; if (obs_ack !== 1'b0 || obs_err !== 1'b0 || obs_data !== q) begin n_fail++;
                    $display("FAIL rand_idle_hold dut%0d got ack=%b err=%b data=%h want 0 0 %h",
                             s, obs_ack, obs_err, obs_data, q); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_k16_bus_ram
`default_nettype wire
